// File: rtl/ifm_buffer_sched.sv
// Tile sequencer for the ifm_buffer bank: it steers loader rows into the buffers
// round-robin, arms img2col, issues counted cubic fetches, then waits for drain.
//
// state | meaning
// IDLE  | waiting for start; config is latched on start
// LOAD  | accept loader beats, one-hot write into buf_sel at wr_ptr
// ARM   | one-cycle i2c_ready pulse
// FETCH | strobe cubic_fetch_en whenever the cube is ready and buffer 0 has data
// DRAIN | wait for buffer 0 to report empty
// DONE  | one-cycle i2c_done / tile_done pulse
module ifm_buffer_sched #(
  parameter int SIZE = 8,
  parameter int AW   = 5
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        wr_rows,
  input  logic [4:0]           fetch_total,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 buf_empty,
  input  logic                 cube_ready,
  output logic [SIZE-1:0]      ifm_wr_en,
  output logic [AW*SIZE-1:0]   ifm_wr_addr,
  output logic                 i2c_ready,
  output logic                 i2c_done,
  output logic                 cubic_fetch_en,
  output logic [4:0]           fetch_num,
  output logic                 busy,
  output logic                 tile_done
);

  localparam int SW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_FETCH, S_DRAIN, S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   buf_sel;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     rows_l;
  logic [4:0]      fcnt;
  logic [5:0]      fet_l;
  logic            beat, last_beat, fetch, last_fetch, sel_wrap;

  assign sel_wrap   = (buf_sel == SW'(SIZE - 1));
  assign beat       = (state == S_LOAD) & in_valid;
  assign last_beat  = beat & sel_wrap & ({1'b0, wr_ptr} == (rows_l - 1'b1));
  assign fetch      = (state == S_FETCH) & cube_ready & ~buf_empty;
  assign last_fetch = fetch & ({1'b0, fcnt} == (fet_l - 6'd1));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start)      state_nx = S_LOAD;
      S_LOAD:  if (last_beat)  state_nx = S_ARM;
      S_ARM:                   state_nx = S_FETCH;
      S_FETCH: if (last_fetch) state_nx = S_DRAIN;
      S_DRAIN: if (buf_empty)  state_nx = S_DONE;
      S_DONE:                  state_nx = S_IDLE;
      default:                 state_nx = S_IDLE;
    endcase
  end

  // Zero in the config ports means the maximum count, so the latched copies are one bit wider.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rows_l  <= '0;
      fet_l   <= '0;
      buf_sel <= '0;
      wr_ptr  <= '0;
      fcnt    <= '0;
    end else if ((state == S_IDLE) && start) begin
      rows_l  <= (wr_rows == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, wr_rows};
      fet_l   <= (fetch_total == 5'd0) ? 6'd32 : {1'b0, fetch_total};
      buf_sel <= '0;
      wr_ptr  <= '0;
      fcnt    <= '0;
    end else if (beat) begin
      if (sel_wrap) begin
        buf_sel <= '0;
        wr_ptr  <= wr_ptr + 1'b1;
      end else begin
        buf_sel <= buf_sel + 1'b1;
      end
    end else if (fetch) begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign ifm_wr_addr = {SIZE{wr_ptr}};
  assign fetch_num   = fcnt;

  always_comb begin
    in_ready       = 1'b0;
    ifm_wr_en      = '0;
    i2c_ready      = 1'b0;
    i2c_done       = 1'b0;
    cubic_fetch_en = 1'b0;
    tile_done      = 1'b0;
    busy           = (state != S_IDLE);
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) ifm_wr_en = SIZE'(1) << buf_sel;
      end
      S_ARM:   i2c_ready      = 1'b1;
      S_FETCH: cubic_fetch_en = cube_ready & ~buf_empty;
      S_DONE: begin
        i2c_done  = 1'b1;
        tile_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ifm_buffer_sched.sv
// Directed bench for ifm_buffer_sched: a cycle table for the nominal tile plus
// scoreboarded sequences for backpressure, max counts, empty stalls, reset and stray starts.
module tb_ifm_buffer_sched;
  localparam int SIZE = 8;
  localparam int AW   = 5;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [AW-1:0] wr_rows = '0;
  logic [4:0] fetch_total = '0;
  logic in_valid = 1'b0;
  logic buf_empty = 1'b0;
  logic cube_ready = 1'b0;
  logic in_ready, i2c_ready, i2c_done, cubic_fetch_en, busy, tile_done;
  logic [SIZE-1:0] ifm_wr_en;
  logic [AW*SIZE-1:0] ifm_wr_addr;
  logic [4:0] fetch_num;

  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clock = ~clock;

  ifm_buffer_sched #(.SIZE(SIZE), .AW(AW)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .wr_rows(wr_rows),
    .fetch_total(fetch_total), .in_valid(in_valid), .in_ready(in_ready),
    .buf_empty(buf_empty), .cube_ready(cube_ready), .ifm_wr_en(ifm_wr_en),
    .ifm_wr_addr(ifm_wr_addr), .i2c_ready(i2c_ready), .i2c_done(i2c_done),
    .cubic_fetch_en(cubic_fetch_en), .fetch_num(fetch_num), .busy(busy),
    .tile_done(tile_done)
  );

  typedef struct {
    logic       iv, cr, be;
    logic       exp_rdy;
    logic [7:0] exp_en;
    logic [4:0] exp_addr;
    logic       exp_arm, exp_fen;
    logic [4:0] exp_fnum;
    logic       exp_busy, exp_done;
  } vec_t;

  vec_t tbl [23];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] outs_all();
    return 64'({in_ready, ifm_wr_en, ifm_wr_addr, i2c_ready, i2c_done,
                cubic_fetch_en, fetch_num, busy, tile_done});
  endfunction

  task automatic do_start(input logic [AW-1:0] wr, input logic [4:0] ft);
    @(negedge clock);
    wr_rows = wr;
    fetch_total = ft;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      #1;
      check({tag, "_idle"}, 64'({busy, tile_done, in_ready, i2c_ready}), 64'(0));
    end
  endtask

  task automatic run_tile(input string tag, input logic [AW-1:0] wr, input logic [4:0] ft,
                          input int nbeats, input int nfetch, input bit bp,
                          input bit empty_stall, input bit start_busy);
    int b, f, arms, dones, last_f, stall_left;
    bit fin, busy_start_sent;
    b = 0; f = 0; arms = 0; dones = 0; last_f = -10; stall_left = 5;
    fin = 0; busy_start_sent = 0;
    do_start(wr, ft);
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      bit stalled;
      @(negedge clock);
      start = 1'b0;
      in_valid   = bp ? (cyc % 2 == 0) : 1'b1;
      cube_ready = bp ? (cyc % 2 == 1) : 1'b1;
      stalled = 0;
      if (f >= nfetch) buf_empty = 1'b1;
      else if (empty_stall && f == 1 && stall_left > 0) begin
        buf_empty = 1'b1;
        stall_left--;
        stalled = 1;
      end else buf_empty = 1'b0;
      if (start_busy && b == 4 && !busy_start_sent) begin
        start = 1'b1;
        busy_start_sent = 1;
      end
      #1;
      check({tag, "_excl"}, 64'({$onehot0(ifm_wr_en), ~((|ifm_wr_en) & cubic_fetch_en)}), 64'(3));
      if (stalled) check({tag, "_stall_nofetch"}, 64'(cubic_fetch_en), 64'(0));
      if (ifm_wr_en != '0) begin
        check({tag, "_wr_en"}, 64'({in_valid, ifm_wr_en}), 64'({1'b1, 8'(1 << (b % 8))}));
        check({tag, "_wr_addr"}, 64'(ifm_wr_addr), 64'({SIZE{5'((b / 8) % 32)}}));
        b++;
      end
      if (i2c_ready) begin
        arms++;
        check({tag, "_arm_order"}, 64'({32'(b), 32'(f)}), {32'(nbeats), 32'(0)});
      end
      if (cubic_fetch_en) begin
        check({tag, "_fetch_num"}, 64'({cube_ready, buf_empty, fetch_num}), 64'({1'b1, 1'b0, 5'(f % 32)}));
        f++;
        last_f = cyc;
      end
      if (tile_done) begin
        dones++;
        check({tag, "_done"}, 64'({i2c_done, 32'(cyc - last_f)}), 64'({1'b1, 32'(2)}));
        if (start_busy) start = 1'b1;
        fin = 1;
      end
    end
    @(negedge clock);
    start = 1'b0;
    #1;
    check({tag, "_timeout"}, 64'(fin), 64'(1));
    check({tag, "_counts"}, {16'(b), 16'(f), 16'(arms), 16'(dones)},
          {16'(nbeats), 16'(nfetch), 16'(1), 16'(1)});
    check({tag, "_post_idle"}, 64'({busy, tile_done}), 64'(0));
    idle_check(tag, 3);
  endtask

  initial begin
    for (int k = 0; k < 23; k++) begin
      tbl[k] = '{iv: 1'b1, cr: 1'b1, be: (k >= 20), exp_rdy: 1'b0, exp_en: 8'h00,
                 exp_addr: 5'd0, exp_arm: 1'b0, exp_fen: 1'b0, exp_fnum: 5'd0,
                 exp_busy: (k < 22), exp_done: 1'b0};
      if (k < 16) begin
        tbl[k].exp_rdy  = 1'b1;
        tbl[k].exp_en   = 8'(1 << (k % 8));
        tbl[k].exp_addr = 5'(k / 8);
      end
      if (k == 16) tbl[k].exp_arm = 1'b1;
      if (k >= 17 && k <= 19) begin
        tbl[k].exp_fen  = 1'b1;
        tbl[k].exp_fnum = 5'(k - 17);
      end
      if (k == 21) tbl[k].exp_done = 1'b1;
    end

    in_valid = 1'b1;
    cube_ready = 1'b1;
    #12;
    check("reset_outs", outs_all(), 64'(0));
    @(negedge clock);
    rst_n = 1'b1;
    in_valid = 1'b0;
    idle_check("after_reset", 2);

    do_start(5'd2, 5'd3);
    for (int k = 0; k < 23; k++) begin
      @(negedge clock);
      in_valid = tbl[k].iv;
      cube_ready = tbl[k].cr;
      buf_empty = tbl[k].be;
      #1;
      check($sformatf("nom%0d_ctl", k),
            64'({in_ready, ifm_wr_en, i2c_ready, cubic_fetch_en, busy, tile_done, i2c_done}),
            64'({tbl[k].exp_rdy, tbl[k].exp_en, tbl[k].exp_arm, tbl[k].exp_fen,
                 tbl[k].exp_busy, tbl[k].exp_done, tbl[k].exp_done}));
      if (tbl[k].exp_rdy)
        check($sformatf("nom%0d_addr", k), 64'(ifm_wr_addr), 64'({SIZE{tbl[k].exp_addr}}));
      if (tbl[k].exp_fen)
        check($sformatf("nom%0d_fnum", k), 64'(fetch_num), 64'(tbl[k].exp_fnum));
    end

    run_tile("bp",    5'd2, 5'd3, 16,  3,  1'b1, 1'b0, 1'b0);
    run_tile("max",   5'd0, 5'd0, 256, 32, 1'b0, 1'b0, 1'b0);
    run_tile("estall", 5'd2, 5'd6, 16, 6,  1'b0, 1'b1, 1'b0);

    begin
      int b;
      b = 0;
      buf_empty = 1'b0;
      do_start(5'd2, 5'd3);
      for (int cyc = 0; cyc < 50 && b < 4; cyc++) begin
        @(negedge clock);
        in_valid = 1'b1;
        #1;
        if (ifm_wr_en != '0) b++;
      end
      check("rst_pre_beats", 64'(b), 64'(4));
      @(negedge clock);
      in_valid = 1'b1;
      #1;
      check("rst_5th_beat", 64'(ifm_wr_en), 64'(8'h10));
      rst_n = 1'b0;
      #1;
      check("rst_async_outs", outs_all(), 64'(0));
      @(negedge clock);
      rst_n = 1'b1;
      in_valid = 1'b0;
      idle_check("rst_after", 3);
    end
    run_tile("rst_rerun", 5'd2, 5'd3, 16, 3, 1'b0, 1'b0, 1'b0);

    run_tile("sbusy", 5'd2, 5'd3, 16, 3, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
